// File: rtl/array_snapshot_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | array_snapshot_reader                                                    |
// | Captures a parallel register array in one clock and streams it out one   |
// | entry per beat over valid/ready, tagging entries changed since last scan.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module array_snapshot_reader #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] in_data,
  input  logic                   snap,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_index,
  output logic                   out_last,
  output logic                   out_changed,
  output logic [7:0]             scan_count
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(DEPTH - 1);

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_pend;
  logic             r_valid;
  logic [7:0]       r_scan_count;
  logic [WIDTH-1:0] r_snap_mem [DEPTH];
  logic [WIDTH-1:0] r_prev_mem [DEPTH];

  logic             w_at_last;
  logic             w_fire;

  assign w_at_last = (r_idx == C_LAST_IDX);
  assign w_fire    = r_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_pend       <= 1'b0;
      r_valid      <= 1'b0;
      r_scan_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_snap_mem[i] <= '0;
        r_prev_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (snap) begin
            for (int i = 0; i < DEPTH; i++) begin
              r_snap_mem[i] <= in_data[i*WIDTH +: WIDTH];
            end
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_fire) begin
            r_prev_mem[r_idx] <= r_snap_mem[r_idx];
            if (!w_at_last) begin
              r_idx <= r_idx + 1'b1;
              if (snap) begin
                r_pend <= 1'b1;
              end
            end else begin
              r_scan_count <= r_scan_count + 8'd1;
              r_idx        <= '0;
              // A queued or coincident request restarts without an idle cycle
              if (r_pend || snap) begin
                for (int i = 0; i < DEPTH; i++) begin
                  r_snap_mem[i] <= in_data[i*WIDTH +: WIDTH];
                end
                r_pend <= 1'b0;
              end else begin
                r_valid <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end else if (snap) begin
            r_pend <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_valid;
  assign out_valid   = r_valid;
  assign out_data    = r_snap_mem[r_idx];
  assign out_index   = r_idx;
  assign out_last    = r_valid & w_at_last;
  assign out_changed = r_valid & (r_snap_mem[r_idx] != r_prev_mem[r_idx]);
  assign scan_count  = r_scan_count;

endmodule
`default_nettype wire

// File: tb/tb_array_snapshot_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_array_snapshot_reader                                                 |
// | Scoreboard bench with a transaction-level reference model.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_array_snapshot_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IDXW  = $clog2(DEPTH);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [DEPTH*WIDTH-1:0] in_data = '0;
  logic                   snap = 1'b0;
  logic                   out_ready = 1'b1;
  logic                   busy, out_valid, out_last, out_changed;
  logic [WIDTH-1:0]       out_data;
  logic [IDXW-1:0]        out_index;
  logic [7:0]             scan_count;

  array_snapshot_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .snap(snap),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_changed(out_changed), .scan_count(scan_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               idx;
    bit               last;
    bit               chg;
  } beat_t;

  beat_t            exp_q[$];
  int               checks = 0;
  int               failures = 0;
  bit               started = 0;
  int               m_left = 0;
  bit               m_pend = 0;
  int               m_count = 0;
  bit               m_cap;
  logic [WIDTH-1:0] m_sent [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats still owed for the current scan, plus one pending request.
  task automatic model_capture();
    beat_t b;
    for (int i = 0; i < DEPTH; i++) begin
      b.data = in_data[i*WIDTH +: WIDTH];
      b.idx  = i;
      b.last = (i == DEPTH - 1);
      b.chg  = (b.data != m_sent[i]);
      m_sent[i] = b.data;
      exp_q.push_back(b);
    end
    m_left = DEPTH;
  endtask

  always @(posedge clk) begin
    m_cap = 0;
    if (!rst_n) begin
      started = 1;
      m_left  = 0;
      m_pend  = 0;
      m_count = 0;
      for (int i = 0; i < DEPTH; i++) m_sent[i] = '0;
      exp_q.delete();
    end else if (started) begin
      if (m_left == 0) begin
        m_cap = snap;
      end else if (out_ready && m_left == 1) begin
        m_left  = 0;
        m_count = (m_count + 1) % 256;
        m_cap   = m_pend || snap;
        m_pend  = 0;
      end else begin
        if (out_ready) m_left--;
        if (snap) m_pend = 1;
      end
      if (m_cap) model_capture();
    end
  end

  bit               stalled = 0;
  logic [WIDTH-1:0] pv_data;
  logic [IDXW-1:0]  pv_index;
  logic             pv_last, pv_chg;
  beat_t            e;

  always @(negedge clk) begin
    if (started) begin
      check("valid", out_valid, m_left > 0);
      check("busy", busy, m_left > 0);
      check("scan_count", scan_count, m_count[7:0]);
      if (stalled) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, pv_data);
        check("stall_index", out_index, pv_index);
        check("stall_last", out_last, pv_last);
        check("stall_changed", out_changed, pv_chg);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_index", out_index, e.idx);
          check("beat_last", out_last, e.last);
          check("beat_changed", out_changed, e.chg);
        end
      end
      stalled  = rst_n && out_valid && !out_ready;
      pv_data  = out_data;
      pv_index = out_index;
      pv_last  = out_last;
      pv_chg   = out_changed;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_entry(input int i, input logic [WIDTH-1:0] v);
    in_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic pulse_snap();
    snap = 1'b1;
    step(1);
    snap = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_index", out_index, '0);
    check("rst_last", out_last, 1'b0);
    check("rst_changed", out_changed, 1'b0);
    check("rst_scan_count", scan_count, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) set_entry(i, WIDTH'(i));
    step(2);
    check_reset_outputs();
    rst_n = 1'b1;

    // Basic scan, then a single-entry change, then an unchanged rescan
    pulse_snap();
    step(6);
    set_entry(0, 8'd4);
    pulse_snap();
    step(6);
    pulse_snap();
    step(6);

    // Backpressure on index 1
    pulse_snap();
    step(1);
    out_ready = 1'b0;
    step(3);
    out_ready = 1'b1;
    step(6);

    // Mid-scan data change with two snap pulses collapsing into one request
    pulse_snap();
    step(1);
    set_entry(3, 8'd7);
    pulse_snap();
    step(1);
    pulse_snap();
    step(12);

    // Reset in the middle of a scan
    pulse_snap();
    step(2);
    rst_n = 1'b0;
    step(1);
    check_reset_outputs();
    rst_n = 1'b1;
    set_entry(0, 8'd5);
    for (int i = 1; i < DEPTH; i++) set_entry(i, 8'd0);
    pulse_snap();
    step(6);

    // 256 back-to-back scans: scan_count wraps
    snap = 1'b1;
    step(256 * DEPTH);
    snap = 1'b0;
    step(2 * DEPTH);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ($urandom_range(0, 2) == 0) set_entry(i, WIDTH'($urandom));
        end
      end
      snap      = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      step(1);
    end

    snap      = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    step(3 * DEPTH + 4);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
